booth_multiplier: RTL and testbench

- Sequential radix-2 Booth multiplier for two's-complement operands.
- Companion to the non-restoring divider; the multiply side of the same arithmetic unit.
- Operand loading, `start`/`done` behaviour and the controller/datapath split match the divider.
- Operands arrive serially on one `data_in` bus. The product appears after N add/shift iterations.

---
 rtl/booth_pkg.sv | 40 ++++
 rtl/booth_controller.sv | 91 +++++++++
 rtl/booth_datapath.sv | 137 +++++++++++++
 rtl/booth_multiplier.sv | 75 +++++++
 tb/tb_booth_multiplier.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
// Module      : booth_pkg
// Description : Shared definitions for the sequential radix-2 Booth
//               multiplier: FSM state encoding, Booth recoding op codes,
//               default operand width and the recoding helper.
// Revision    : 1.0 - initial release
// ============================================================================
package booth_pkg;

  // Default operand width (legal range 2..16)
  localparam int N_DEFAULT = 8;

  // Controller states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_M = 3'd1,
    LOAD_Q = 3'd2,
    CALC   = 3'd3,
    DONE   = 3'd4
  } state_e;

  // Booth recoding of the {Q[0], q_1} pair
  typedef enum logic [1:0] {
    NOP = 2'd0,
    ADD = 2'd1,
    SUB = 2'd2
  } op_e;

  // 01 -> add M, 10 -> subtract M, 00/11 -> no arithmetic this iteration
  function automatic op_e booth_op(input logic q0, input logic q_1);
    case ({q0, q_1})
      2'b01:   return ADD;
      2'b10:   return SUB;
      default: return NOP;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/booth_controller.sv
`default_nettype none
// ============================================================================
// Module      : booth_controller
// Description : Five-state control FSM of the Booth multiplier. Sequences
//               operand loading, the N add/shift iterations and the
//               one-cycle done pulse; drives the datapath strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_controller
  import booth_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic q0,
  input  logic q_1,
  input  logic eqz,
  output logic ldm,
  output logic ldq,
  output logic clra,
  output logic add,
  output logic sub,
  output logic shift,
  output logic ldp,
  output logic done,
  output logic busy
);

  state_e state_q;
  state_e state_d;
  op_e    op;

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and strobe decode; every output defaults to inactive
  always_comb begin
    state_d = state_q;
    op      = booth_op(q0, q_1);
    ldm     = 1'b0;
    ldq     = 1'b0;
    clra    = 1'b0;
    add     = 1'b0;
    sub     = 1'b0;
    shift   = 1'b0;
    ldp     = 1'b0;
    done    = 1'b0;
    busy    = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD_M;
        end
      end
      LOAD_M: begin
        ldm     = 1'b1;
        state_d = LOAD_Q;
      end
      LOAD_Q: begin
        ldq     = 1'b1;
        clra    = 1'b1;
        state_d = CALC;
      end
      CALC: begin
        shift = 1'b1;
        add   = (op == ADD);
        sub   = (op == SUB);
        // eqz marks the iteration whose decrement reaches zero
        if (eqz) begin
          ldp     = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/booth_datapath.sv
`default_nettype none
// ============================================================================
// Module      : booth_datapath
// Description : Booth multiplier datapath: A (N+1 bits), Q, M (sign-extended
//               to N+1 bits), q_1, iteration count, adder/subtractor and the
//               product register. Optional status flags under macro
//               BOOTH_STATUS_EN (zero / negative product).
// Revision    : 1.0 - initial release
// ============================================================================
module booth_datapath
  import booth_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   data_in,
  input  logic           ldm,
  input  logic           ldq,
  input  logic           clra,
  input  logic           add,
  input  logic           sub,
  input  logic           shift,
  input  logic           ldp,
  output logic           q0,
  output logic           q_1,
  output logic           eqz,
  output logic [2*N-1:0] product
`ifdef BOOTH_STATUS_EN
  ,
  output logic           zero,
  output logic           neg
`endif
);

  localparam int CW = $clog2(N + 1);

  logic [N:0]     a_q, a_d;
  logic [N:0]     m_q, m_d;
  logic [N-1:0]   q_q, q_d;
  logic           q1_q, q1_d;
  logic [CW-1:0]  count_q, count_d;
  logic [2*N-1:0] product_q, product_d;
  logic [N:0]     sum;
`ifdef BOOTH_STATUS_EN
  logic           zero_q, zero_d;
  logic           neg_q, neg_d;
`endif

  // Datapath registers, all cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      m_q       <= '0;
      q_q       <= '0;
      q1_q      <= 1'b0;
      count_q   <= '0;
      product_q <= '0;
`ifdef BOOTH_STATUS_EN
      zero_q    <= 1'b0;
      neg_q     <= 1'b0;
`endif
    end else begin
      a_q       <= a_d;
      m_q       <= m_d;
      q_q       <= q_d;
      q1_q      <= q1_d;
      count_q   <= count_d;
      product_q <= product_d;
`ifdef BOOTH_STATUS_EN
      zero_q    <= zero_d;
      neg_q     <= neg_d;
`endif
    end
  end

  // Operand load, A+-M, arithmetic shift of {A,Q,q_1}, and product capture
  always_comb begin
    a_d       = a_q;
    m_d       = m_q;
    q_d       = q_q;
    q1_d      = q1_q;
    count_d   = count_q;
    product_d = product_q;
    // N+1-bit arithmetic keeps A-M exact even for M = -2^(N-1)
    sum       = a_q;
    if (add) begin
      sum = a_q + m_q;
    end else if (sub) begin
      sum = a_q - m_q;
    end
    if (ldm) begin
      m_d = {data_in[N-1], data_in};
    end
    if (ldq) begin
      q_d = data_in;
    end
    if (clra) begin
      a_d     = '0;
      q1_d    = 1'b0;
      count_d = CW'(N);
    end
    if (shift) begin
      a_d     = {sum[N], sum[N:1]};
      q_d     = {sum[0], q_q[N-1:1]};
      q1_d    = q_q[0];
      count_d = count_q - CW'(1);
    end
    // Product is taken from the post-shift value of the final iteration
    if (ldp) begin
      product_d = {a_d[N-1:0], q_d};
    end
  end

`ifdef BOOTH_STATUS_EN
  // Status flags follow the product register on the same edge
  always_comb begin
    zero_d = zero_q;
    neg_d  = neg_q;
    if (ldp) begin
      zero_d = (product_d == '0);
      neg_d  = product_d[2*N-1];
    end
  end

  assign zero = zero_q;
  assign neg  = neg_q;
`endif

  assign q0      = q_q[0];
  assign q_1     = q1_q;
  // High on the iteration whose decrement brings count to zero
  assign eqz     = (count_q == CW'(1));
  assign product = product_q;

endmodule
`default_nettype wire

// File: rtl/booth_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : booth_multiplier
// Description : Sequential radix-2 Booth multiplier for two's-complement
//               operands. Multiplicand then multiplier arrive serially on
//               data_in; the 2N-bit product follows N add/shift iterations.
//               Optional zero/neg status outputs under macro BOOTH_STATUS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_multiplier
  import booth_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   data_in,
  output logic [2*N-1:0] product,
  output logic           done,
  output logic           busy
`ifdef BOOTH_STATUS_EN
  ,
  output logic           zero,
  output logic           neg
`endif
);

  logic ldm, ldq, clra, add, sub, shift, ldp;
  logic q0, q_1, eqz;

  booth_controller u_ctrl (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .q0    (q0),
    .q_1   (q_1),
    .eqz   (eqz),
    .ldm   (ldm),
    .ldq   (ldq),
    .clra  (clra),
    .add   (add),
    .sub   (sub),
    .shift (shift),
    .ldp   (ldp),
    .done  (done),
    .busy  (busy)
  );

  booth_datapath #(
    .N (N)
  ) u_dp (
    .clk     (clk),
    .rst     (rst),
    .data_in (data_in),
    .ldm     (ldm),
    .ldq     (ldq),
    .clra    (clra),
    .add     (add),
    .sub     (sub),
    .shift   (shift),
    .ldp     (ldp),
    .q0      (q0),
    .q_1     (q_1),
    .eqz     (eqz),
    .product (product)
`ifdef BOOTH_STATUS_EN
    ,
    .zero    (zero),
    .neg     (neg)
`endif
  );

endmodule
`default_nettype wire

// File: tb/tb_booth_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_multiplier
// Description : Self-checking bench for booth_multiplier (N=8): directed
//               vector table, mid-operation reset, back-to-back operation
//               with start held high and noisy inputs during CALC.
//               Status outputs checked when BOOTH_STATUS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_multiplier;

  localparam int N  = 8;
  localparam int NV = 10;

  logic           clk;
  logic           rst;
  logic           start;
  logic [N-1:0]   data_in;
  logic [2*N-1:0] product;
  logic           done;
  logic           busy;
`ifdef BOOTH_STATUS_EN
  logic           zero;
  logic           neg;
`endif

  int  n_checks;
  int  n_fail;
  time last_done;

  typedef struct {
    logic [7:0]  m;
    logic [7:0]  q;
    logic [15:0] p;
    logic        z;
    logic        n;
  } vec_t;

  vec_t vecs [NV];

  booth_multiplier #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .data_in (data_in),
    .product (product),
    .done    (done),
    .busy    (busy)
`ifdef BOOTH_STATUS_EN
    ,
    .zero    (zero),
    .neg     (neg)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One complete operation, entered #1 after an edge with the DUT in IDLE.
  // keep: value left on start afterwards; noisy: scramble start/data_in in CALC;
  // chk_int: require the done edge to follow the previous one by N+4 cycles.
  task automatic run_op(input string tag, input vec_t v, input bit noisy,
                        input bit keep, input bit chk_int);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    start   = 1'b1;
    data_in = 8'($urandom);
    @(posedge clk); #1;                         // edge k
    check({tag, "_busy_rise"}, 32'(busy), 32'd1);
    start   = noisy ? 1'($urandom) : 1'b0;
    data_in = v.m;
    @(posedge clk); #1;                         // edge k+1: M sampled
    data_in = v.q;
    @(posedge clk); #1;                         // edge k+2: Q sampled
    for (int i = 0; i < N; i++) begin
      if (noisy) begin
        start   = 1'($urandom);
        data_in = 8'($urandom);
      end
      check({tag, "_no_early_done"}, 32'(done), 32'd0);
      @(posedge clk); #1;                       // edges k+3..k+N+2
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_product"}, 32'(product), 32'(v.p));
    check({tag, "_busy_done"}, 32'(busy), 32'd1);
`ifdef BOOTH_STATUS_EN
    check({tag, "_zero"}, 32'(zero), 32'(v.z));
    check({tag, "_neg"}, 32'(neg), 32'(v.n));
`endif
    if (chk_int) begin
      check({tag, "_interval"}, 32'(($time - last_done) / 10), 32'(N + 4));
    end
    last_done = $time;
    start     = keep;
    @(posedge clk); #1;                         // edge k+N+3
    check({tag, "_done_fall"}, 32'(done), 32'd0);
    check({tag, "_busy_fall"}, 32'(busy), 32'd0);
    check({tag, "_product_hold"}, 32'(product), 32'(v.p));
  endtask

  initial begin
    vec_t v;
    n_checks  = 0;
    n_fail    = 0;
    last_done = 0;
    rst       = 1'b1;
    start     = 1'b0;
    data_in   = '0;

    //           m      q      product   z     n
    vecs[0] = '{8'h07, 8'h03, 16'h0015, 1'b0, 1'b0};  //    7 *    3 =    21
    vecs[1] = '{8'hFB, 8'h03, 16'hFFF1, 1'b0, 1'b1};  //   -5 *    3 =   -15
    vecs[2] = '{8'h80, 8'h80, 16'h4000, 1'b0, 1'b0};  // -128 * -128 = 16384
    vecs[3] = '{8'h7F, 8'h80, 16'hC080, 1'b0, 1'b1};  //  127 * -128 = -16256
    vecs[4] = '{8'h00, 8'h5A, 16'h0000, 1'b1, 1'b0};  //    0 *   90 =     0
    vecs[5] = '{8'hFF, 8'hFF, 16'h0001, 1'b0, 1'b0};  //   -1 *   -1 =     1
    vecs[6] = '{8'h80, 8'h7F, 16'hC080, 1'b0, 1'b1};  // -128 *  127 = -16256
    vecs[7] = '{8'h7F, 8'h7F, 16'h3F01, 1'b0, 1'b0};  //  127 *  127 = 16129
    vecs[8] = '{8'hFF, 8'h80, 16'h0080, 1'b0, 1'b0};  //   -1 * -128 =   128
    vecs[9] = '{8'h05, 8'hFD, 16'hFFF1, 1'b0, 1'b1};  //    5 *   -3 =   -15

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_product", 32'(product), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
`ifdef BOOTH_STATUS_EN
    check("reset_zero", 32'(zero), 32'd0);
    check("reset_neg", 32'(neg), 32'd0);
`endif
    @(posedge clk); #1;

    // Directed table, one idle cycle between operations
    for (int i = 0; i < NV; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i], 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
    end

    // Completed 7x3, then reset at the 4th CALC edge of 0x12 x 0x34
    run_op("pre_rst", vecs[0], 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;                         // edge k
    start   = 1'b0;
    data_in = 8'h12;
    @(posedge clk); #1;                         // edge k+1
    data_in = 8'h34;
    @(posedge clk); #1;                         // edge k+2
    repeat (3) @(posedge clk);                  // CALC edges 1..3
    #1;
    rst = 1'b1;
    @(posedge clk); #1;                         // CALC edge 4 sees reset
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_product", 32'(product), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check("midrst_no_done", 32'(done), 32'd0);
      check("midrst_stay_idle", 32'(busy), 32'd0);
    end

    // Recovery after the aborted operation
    v = '{8'h12, 8'h34, 16'h03A8, 1'b0, 1'b0};  // 18 * 52 = 936
    run_op("recover", v, 1'b0, 1'b0, 1'b0);

    // start held high, noisy inputs during CALC, results every N+4 cycles
    run_op("b2b0", vecs[0], 1'b1, 1'b1, 1'b0);
    run_op("b2b1", vecs[1], 1'b1, 1'b1, 1'b1);
    run_op("b2b2", vecs[3], 1'b1, 1'b1, 1'b1);
    run_op("b2b3", vecs[4], 1'b1, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
